counter_ctrl: RTL and testbench

- Command-driven sequencer directly upstream of the 4-bit loadable up-counter.
- Accepts start/stop/pause commands over a valid/ready interface and drives the counter's load, load_val and enable.
- Watches the returned count_val for a programmed terminal value and emits a one-cycle terminal-count pulse.
- Supports one-shot and auto-reload modes and a fixed enable prescaler.

---
 rtl/counter_pkg.sv | 26 ++
 rtl/prescale_div.sv | 40 ++++
 rtl/counter_ctrl.sv | 154 +++++++++++++++
 tb/tb_counter_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter sequencer: command opcodes, FSM states,
// and the default counter width.
package counter_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    CMD_START_ONESHOT = 2'd0,
    CMD_START_RELOAD  = 2'd1,
    CMD_STOP          = 2'd2,
    CMD_PAUSE_TOGGLE  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } ctrl_state_e;

  // Both START flavours behave identically apart from the latched mode bit.
  function automatic logic is_start_op(input cmd_op_e op);
    return (op == CMD_START_ONESHOT) || (op == CMD_START_RELOAD);
  endfunction

endpackage

// File: rtl/prescale_div.sv
// Enable prescaler: counts 0..PRESCALE-1 while advancing, wraps, and
// raises tick on the last phase. clr wins over adv; otherwise it holds.
module prescale_div #(
  parameter int PRESCALE = 1,
  parameter int PDIV_W   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  output logic tick
);

  localparam logic [PDIV_W-1:0] LAST = PDIV_W'(PRESCALE - 1);

  logic [PDIV_W-1:0] pdiv_reg;
  logic [PDIV_W-1:0] pdiv_next;

  // Next divider value: clear, wrap on the last phase, or step by one.
  always_comb begin
    pdiv_next = pdiv_reg;
    if (clr) begin
      pdiv_next = '0;
    end else if (adv) begin
      pdiv_next = (pdiv_reg == LAST) ? '0 : pdiv_reg + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pdiv_reg <= '0;
    end else begin
      pdiv_reg <= pdiv_next;
    end
  end

  assign tick = (pdiv_reg == LAST);

endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for a loadable up-counter. Accepts
// start/stop/pause commands, loads and enables the counter, and pulses
// tc_pulse one cycle after the returned count reaches the terminal value.
// Optional: define COUNTER_CTRL_TC_COUNT_EN to add a saturating 8-bit
// tc_count output (cleared on reset and on every accepted START).
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH    = CNT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_term,
  input  logic [WIDTH-1:0] count_val,
  output logic             load,
  output logic [WIDTH-1:0] load_val,
  output logic             enable,
  output logic             tc_pulse,
  output logic             busy
`ifdef COUNTER_CTRL_TC_COUNT_EN
  ,
  output logic [7:0]       tc_count
`endif
);

  localparam int PDIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  ctrl_state_e      state_reg;
  ctrl_state_e      state_next;
  cmd_op_e          op;
  logic [WIDTH-1:0] start_reg;
  logic [WIDTH-1:0] term_reg;
  logic             mode_reg;     // 1 = auto-reload
  logic             tc_pulse_reg;
  logic             busy_reg;
  logic             cmd_fire;
  logic             start_fire;
  logic             term_hit;
  logic             tc_event;
  logic             pdiv_tick;

  assign op         = cmd_op_e'(cmd_op);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign start_fire = cmd_fire && is_start_op(op);
  assign term_hit   = (state_reg == ST_RUN) && (count_val == term_reg);
  // An accepted command in the same cycle suppresses terminal reporting.
  assign tc_event   = term_hit && !cmd_fire;

  // The divider only advances while running; a START or a reported
  // terminal restarts it, and PAUSE simply stops advancing it.
  prescale_div #(
    .PRESCALE (PRESCALE),
    .PDIV_W   (PDIV_W)
  ) u_pdiv (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_fire || tc_event),
    .adv  (state_reg == ST_RUN),
    .tick (pdiv_tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: commands first, then terminal detection in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_fire) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (cmd_fire) begin
          case (op)
            CMD_START_ONESHOT, CMD_START_RELOAD: state_next = ST_LOAD;
            CMD_STOP:         state_next = ST_IDLE;
            CMD_PAUSE_TOGGLE: state_next = (state_reg == ST_RUN) ? ST_PAUSE : ST_RUN;
            default:          state_next = state_reg;
          endcase
        end else if (term_hit) begin
          state_next = mode_reg ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs; enable is the only path combinational on count_val.
  always_comb begin
    cmd_ready = (state_reg != ST_LOAD);
    load      = (state_reg == ST_LOAD);
    load_val  = (state_reg == ST_LOAD) ? start_reg : '0;
    enable    = (state_reg == ST_RUN) && pdiv_tick && (count_val != term_reg);
  end

  // Latch the command operands on every accepted START.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_reg <= '0;
      term_reg  <= '0;
      mode_reg  <= 1'b0;
    end else if (start_fire) begin
      start_reg <= cmd_start;
      term_reg  <= cmd_term;
      mode_reg  <= (op == CMD_START_RELOAD);
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_pulse_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      tc_pulse_reg <= tc_event;
      busy_reg     <= (state_next != ST_IDLE);
    end
  end

  assign tc_pulse = tc_pulse_reg;
  assign busy     = busy_reg;

`ifdef COUNTER_CTRL_TC_COUNT_EN
  logic [7:0] tc_count_reg;

  // Saturating count of terminal pulses since the last START.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc_count_reg <= '0;
    end else if (start_fire) begin
      tc_count_reg <= '0;
    end else if (tc_pulse_reg && (tc_count_reg != 8'hFF)) begin
      tc_count_reg <= tc_count_reg + 8'd1;
    end
  end

  assign tc_count = tc_count_reg;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: two instances (PRESCALE=1 and PRESCALE=3), each
// feeding a behavioural 4-bit counter. A command-level reference model is
// compared against every output on every cycle; a vector table and
// hand-written sequences cover the listed corner cases.
module tb_counter_ctrl;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_PAUSE = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld [2];
  logic [1:0] op  [2];
  logic [3:0] cst [2];
  logic [3:0] ctm [2];
  logic [3:0] cnt [2];
  logic       rdy [2];
  logic       ld  [2];
  logic [3:0] lv  [2];
  logic       en  [2];
  logic       tc  [2];
  logic       bsy [2];
`ifdef COUNTER_CTRL_TC_COUNT_EN
  logic [7:0] tcc [2];
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(4), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(vld[0]), .cmd_ready(rdy[0]), .cmd_op(op[0]),
    .cmd_start(cst[0]), .cmd_term(ctm[0]), .count_val(cnt[0]), .load(ld[0]),
    .load_val(lv[0]), .enable(en[0]), .tc_pulse(tc[0]), .busy(bsy[0])
`ifdef COUNTER_CTRL_TC_COUNT_EN
    , .tc_count(tcc[0])
`endif
  );

  counter_ctrl #(.WIDTH(4), .PRESCALE(3)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(vld[1]), .cmd_ready(rdy[1]), .cmd_op(op[1]),
    .cmd_start(cst[1]), .cmd_term(ctm[1]), .count_val(cnt[1]), .load(ld[1]),
    .load_val(lv[1]), .enable(en[1]), .tc_pulse(tc[1]), .busy(bsy[1])
`ifdef COUNTER_CTRL_TC_COUNT_EN
    , .tc_count(tcc[1])
`endif
  );

  // Downstream loadable up-counters driven by the DUT outputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst)        cnt[k] <= 4'd0;
      else if (ld[k]) cnt[k] <= lv[k];
      else if (en[k]) cnt[k] <= cnt[k] + 4'd1;
    end
  end

  // Reference model state (phase, operands, RUN cycles since divider clear).
  int         m_ph [2], n_ph [2];
  logic [3:0] m_st [2], n_st [2];
  logic [3:0] m_tm [2], n_tm [2];
  bit         m_rl [2], n_rl [2];
  int         m_tk [2], n_tk [2];
  bit         m_tc [2], n_tc [2];
  bit         m_bz [2], n_bz [2];
  int         m_tn [2], n_tn [2];

  function automatic int ps(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs with the model and compute the model's next state.
  task automatic model_eval();
    bit e_rdy, e_ld, e_en, hit, acc, is_start;
    logic [3:0] e_lv;
    for (int k = 0; k < 2; k++) begin
      e_rdy    = (m_ph[k] != PH_LOAD);
      e_ld     = (m_ph[k] == PH_LOAD);
      e_lv     = e_ld ? m_st[k] : 4'd0;
      hit      = (m_ph[k] == PH_RUN) && (cnt[k] == m_tm[k]);
      e_en     = (m_ph[k] == PH_RUN) && ((m_tk[k] % ps(k)) == ps(k) - 1) && !hit;
      acc      = vld[k] && e_rdy;
      is_start = (op[k] == 2'd0) || (op[k] == 2'd1);
      check($sformatf("ready%0d", k), rdy[k], e_rdy);
      check($sformatf("load%0d", k), ld[k], e_ld);
      check($sformatf("load_val%0d", k), lv[k], e_lv);
      check($sformatf("enable%0d", k), en[k], e_en);
      check($sformatf("tc_pulse%0d", k), tc[k], m_tc[k]);
      check($sformatf("busy%0d", k), bsy[k], m_bz[k]);
`ifdef COUNTER_CTRL_TC_COUNT_EN
      check($sformatf("tc_count%0d", k), tcc[k], m_tn[k]);
`endif
      n_ph[k] = m_ph[k]; n_st[k] = m_st[k]; n_tm[k] = m_tm[k]; n_rl[k] = m_rl[k];
      n_tk[k] = m_tk[k]; n_tc[k] = 1'b0; n_tn[k] = m_tn[k];
      if (rst) begin
        n_ph[k] = PH_IDLE; n_st[k] = 4'd0; n_tm[k] = 4'd0; n_rl[k] = 1'b0;
        n_tk[k] = 0; n_tn[k] = 0;
      end else begin
        if (acc && is_start) begin
          n_st[k] = cst[k]; n_tm[k] = ctm[k]; n_rl[k] = (op[k] == 2'd1);
          n_tk[k] = 0; n_ph[k] = PH_LOAD;
        end else if (acc && op[k] == 2'd2) begin
          if (m_ph[k] == PH_RUN) n_tk[k] = m_tk[k] + 1;
          n_ph[k] = PH_IDLE;
        end else if (acc && op[k] == 2'd3) begin
          if (m_ph[k] == PH_RUN) begin
            n_tk[k] = m_tk[k] + 1; n_ph[k] = PH_PAUSE;
          end else if (m_ph[k] == PH_PAUSE) begin
            n_ph[k] = PH_RUN;
          end
        end else if (m_ph[k] == PH_LOAD) begin
          n_ph[k] = PH_RUN;
        end else if (m_ph[k] == PH_RUN) begin
          if (hit) begin
            n_tk[k] = 0; n_tc[k] = 1'b1;
            n_ph[k] = m_rl[k] ? PH_LOAD : PH_IDLE;
          end else begin
            n_tk[k] = m_tk[k] + 1;
          end
        end
        if (acc && is_start)              n_tn[k] = 0;
        else if (m_tc[k] && m_tn[k] < 255) n_tn[k] = m_tn[k] + 1;
      end
      n_bz[k] = (n_ph[k] != PH_IDLE);
    end
  endtask

  task automatic cycle_end();
    model_eval();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = n_ph[k]; m_st[k] = n_st[k]; m_tm[k] = n_tm[k]; m_rl[k] = n_rl[k];
      m_tk[k] = n_tk[k]; m_tc[k] = n_tc[k]; m_bz[k] = n_bz[k]; m_tn[k] = n_tn[k];
    end
    #1;
  endtask

  task automatic clk1();
    @(negedge clk);
    cycle_end();
  endtask

  // Present a command and hold it until accepted (bounded).
  task automatic send_cmd(int k, logic [1:0] o, logic [3:0] s, logic [3:0] t);
    bit done;
    done = 1'b0;
    vld[k] = 1'b1; op[k] = o; cst[k] = s; ctm[k] = t;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = rdy[k];
      cycle_end();
    end
    vld[k] = 1'b0;
    check($sformatf("accept%0d", k), done, 1);
  endtask

  typedef struct {
    bit       v;
    bit [1:0] o;
    bit [3:0] s, t;
    bit       r, l;
    bit [3:0] lvx;
    bit       e, p, b;
    bit [3:0] c;
  } vec_t;

  function automatic vec_t mk(bit v, bit [1:0] o, bit [3:0] s, bit [3:0] t, bit r, bit l,
                              bit [3:0] lvx, bit e, bit p, bit b, bit [3:0] c);
    vec_t x;
    x.v = v; x.o = o; x.s = s; x.t = t; x.r = r; x.l = l; x.lvx = lvx;
    x.e = e; x.p = p; x.b = b; x.c = c;
    return x;
  endfunction

  vec_t tbl [9];

  initial begin
    int np, last, ntc, nen, first_en, tc_at;
    bit found, seen;
    logic [3:0] wexp [4];

    // Basic one-shot on the PRESCALE=1 instance, start=3 term=7.
    //            v op s  t   rdy ld lv en tc busy cnt
    tbl[0] = mk(1, 0, 3, 7,  1,  0, 0, 0, 0, 0,  0);
    tbl[1] = mk(0, 0, 0, 0,  0,  1, 3, 0, 0, 1,  0);
    tbl[2] = mk(0, 0, 0, 0,  1,  0, 0, 1, 0, 1,  3);
    tbl[3] = mk(0, 0, 0, 0,  1,  0, 0, 1, 0, 1,  4);
    tbl[4] = mk(0, 0, 0, 0,  1,  0, 0, 1, 0, 1,  5);
    tbl[5] = mk(0, 0, 0, 0,  1,  0, 0, 1, 0, 1,  6);
    tbl[6] = mk(0, 0, 0, 0,  1,  0, 0, 0, 0, 1,  7);
    tbl[7] = mk(0, 0, 0, 0,  1,  0, 0, 0, 1, 0,  7);
    tbl[8] = mk(0, 0, 0, 0,  1,  0, 0, 0, 0, 0,  7);

    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; op[k] = 2'd0; cst[k] = 4'd0; ctm[k] = 4'd0;
      m_ph[k] = PH_IDLE; m_st[k] = 4'd0; m_tm[k] = 4'd0; m_rl[k] = 1'b0;
      m_tk[k] = 0; m_tc[k] = 1'b0; m_bz[k] = 1'b0; m_tn[k] = 0;
    end
    rst = 1'b1;
    repeat (3) clk1();
    rst = 1'b0;
    clk1();

    for (int i = 0; i < 9; i++) begin
      vld[0] = tbl[i].v; op[0] = tbl[i].o; cst[0] = tbl[i].s; ctm[0] = tbl[i].t;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", i), rdy[0], tbl[i].r);
      check($sformatf("tbl%0d_load", i), ld[0], tbl[i].l);
      check($sformatf("tbl%0d_load_val", i), lv[0], tbl[i].lvx);
      check($sformatf("tbl%0d_enable", i), en[0], tbl[i].e);
      check($sformatf("tbl%0d_tc", i), tc[0], tbl[i].p);
      check($sformatf("tbl%0d_busy", i), bsy[0], tbl[i].b);
      check($sformatf("tbl%0d_count", i), cnt[0], tbl[i].c);
      cycle_end();
    end
    vld[0] = 1'b0;

    // Reload with wrap: 14,15,0,1 then reload, tc every 5 cycles.
    wexp[0] = 4'd14; wexp[1] = 4'd15; wexp[2] = 4'd0; wexp[3] = 4'd1;
    send_cmd(0, 2'd1, 4'd14, 4'd1);
    np = 0; last = -1;
    for (int c = 0; c < 40 && np < 4; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) check($sformatf("wrap_cnt%0d", c), cnt[0], wexp[c-1]);
      if (tc[0]) begin
        if (last >= 0) check("reload_period", c - last, 5);
        last = c;
        np++;
      end
      cycle_end();
    end
    check("reload_pulses", np, 4);
    send_cmd(0, 2'd2, 4'd0, 4'd0);
    @(negedge clk);
    check("stop_busy", bsy[0], 0);
    cycle_end();
    ntc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); ntc += int'(tc[0]); cycle_end();
    end
    check("stop_no_tc", ntc, 0);

    // Prescale 3 with a pause, start=0 term=2.
    send_cmd(1, 2'd0, 4'd0, 4'd2);
    nen = 0; first_en = -1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (en[1]) begin nen++; if (first_en < 0) first_en = c; end
      cycle_end();
    end
    check("prescale_first_en", first_en, 3);
    send_cmd(1, 2'd3, 4'd0, 4'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("pause_count", cnt[1], 1);
      check("pause_enable", en[1], 0);
      cycle_end();
    end
    send_cmd(1, 2'd3, 4'd0, 4'd0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (en[1]) nen++;
      if (tc[1]) seen = 1'b1;
      cycle_end();
    end
    check("prescale_tc_seen", seen, 1);
    check("prescale_enables", nen, 2);

    // start == term: tc two cycles after LOAD, never an enable.
    send_cmd(0, 2'd0, 4'd5, 4'd5);
    nen = 0; tc_at = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (en[0]) nen++;
      if (tc[0] && tc_at < 0) tc_at = c;
      cycle_end();
    end
    check("eq_tc_offset", tc_at, 2);
    check("eq_no_enable", nen, 0);

    // START presented during LOAD is held off, then accepted in RUN.
    send_cmd(0, 2'd0, 4'd2, 4'd9);
    vld[0] = 1'b1; op[0] = 2'd0; cst[0] = 4'd4; ctm[0] = 4'd6;
    @(negedge clk);
    check("hold_ready_in_load", rdy[0], 0);
    check("hold_load_val", lv[0], 2);
    cycle_end();
    @(negedge clk);
    check("hold_ready_in_run", rdy[0], 1);
    cycle_end();
    vld[0] = 1'b0;
    @(negedge clk);
    check("hold_reload", ld[0], 1);
    check("hold_reload_val", lv[0], 4);
    cycle_end();
    send_cmd(0, 2'd2, 4'd0, 4'd0);

    // Reset in the middle of a run.
    send_cmd(0, 2'd0, 4'd0, 4'd9);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (cnt[0] == 4'd4) begin found = 1'b1; rst = 1'b1; end
      cycle_end();
    end
    rst = 1'b0;
    check("rst_found_count4", found, 1);
    @(negedge clk);
    check("rst_load", ld[0], 0);
    check("rst_load_val", lv[0], 0);
    check("rst_enable", en[0], 0);
    check("rst_tc", tc[0], 0);
    check("rst_busy", bsy[0], 0);
    cycle_end();
    ntc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); ntc += int'(tc[0]); cycle_end();
    end
    check("rst_no_tc", ntc, 0);

    // Randomized commands on both instances against the model.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(3) == 0);
        op[k]  = 2'($urandom_range(3));
        cst[k] = 4'($urandom_range(15));
        ctm[k] = cst[k] + 4'($urandom_range(5));
      end
      rst = ($urandom_range(149) == 0);
      clk1();
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    clk1();

`ifdef COUNTER_CTRL_TC_COUNT_EN
    // Reload start=0 term=0 pulses every 2 cycles; run long enough to saturate.
    send_cmd(0, 2'd1, 4'd0, 4'd0);
    repeat (600) clk1();
    @(negedge clk);
    check("tc_count_sat", tcc[0], 255);
    cycle_end();
    send_cmd(0, 2'd0, 4'd3, 4'd3);
    @(negedge clk);
    check("tc_count_clear", tcc[0], 0);
    cycle_end();
    repeat (5) clk1();
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
